// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Serial front end of the SPI-to-RAM subsystem. Deserialises (ADDR_SIZE+2)-bit
// MOSI frames into command/payload words for the memory, and on a read-data
// frame returns the memory's byte on MISO, MSB first. It tracks whether a read
// address has been loaded so that read-address and read-data frames alternate.
//
// Ports:
//   clk       in   system clock, also the SPI bit clock (one bit per cycle)
//   rst_n     in   synchronous active-low reset
//   ss_n      in   slave select, active-low, frame boundary
//   mosi      in   serial data in, MSB first
//   miso      out  serial data out, MSB first, registered, 0 when idle
//   rx_data   out  received frame: [ADDR_SIZE+1:ADDR_SIZE] command, rest payload
//   rx_valid  out  one-cycle strobe, rx_data valid
//   tx_data   in   read byte from memory
//   tx_valid  in   tx_data valid strobe (only honoured while waiting for it)
//
// Build option:
//   SPI_CMD_CHECK_EN  when defined, a frame whose command bits do not match the
//                     decoded state is dropped (no rx_valid, flag unchanged).
// -----------------------------------------------------------------------------
module spi_slave #(
   parameter int ADDR_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ss_n,
   input  logic                   mosi,
   output logic                   miso,
   output logic [ADDR_SIZE+1:0]   rx_data,
   output logic                   rx_valid,
   input  logic [ADDR_SIZE-1:0]   tx_data,
   input  logic                   tx_valid
);

   localparam int FW = ADDR_SIZE + 2;
   localparam int CW = $clog2(FW);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CHK_CMD   = 3'd1;
   localparam logic [2:0] WRITE     = 3'd2;
   localparam logic [2:0] READ_ADD  = 3'd3;
   localparam logic [2:0] READ_DATA = 3'd4;
   localparam logic [2:0] WAIT_TX   = 3'd5;
   localparam logic [2:0] SHIFT_OUT = 3'd6;
   localparam logic [2:0] DONE      = 3'd7;

   // Receive: counter runs 0..ADDR_SIZE while the remaining bits arrive; the
   // extra cycle at RX_LAST publishes the word, so rx_valid lands at cycle
   // ADDR_SIZE+3 counted from the edge that first sees ss_n low.
   localparam logic [CW-1:0] RX_LAST = CW'(ADDR_SIZE + 1);
   // Transmit: the MSB is already on miso when SHIFT_OUT is entered, so
   // ADDR_SIZE-1 further bits follow before the line is returned to 0.
   localparam logic [CW-1:0] TX_LAST = CW'(ADDR_SIZE - 1);

   logic [2:0]           r_state;
   logic [CW-1:0]        r_cnt;
   logic [FW-1:0]        r_rx_shift;
   logic [FW-1:0]        r_rx_data;
   logic                 r_rx_valid;
   logic [ADDR_SIZE-1:0] r_tx_shift;
   logic                 r_miso;
   logic                 r_rd_addr_flag;
   logic                 w_cmd_ok;

`ifdef SPI_CMD_CHECK_EN
   logic [1:0] w_cmd;
   always_comb begin
      w_cmd    = r_rx_shift[FW-1:FW-2];
      w_cmd_ok = 1'b0;
      case (r_state)
         WRITE:     w_cmd_ok = ~w_cmd[1];
         READ_ADD:  w_cmd_ok = (w_cmd == 2'b10);
         READ_DATA: w_cmd_ok = (w_cmd == 2'b11);
         default:   w_cmd_ok = 1'b0;
      endcase
   end
`else
   // The memory decodes the command bits; every complete frame is forwarded.
   always_comb begin
      w_cmd_ok = 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_rx_shift     <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_tx_shift     <= '0;
         r_miso         <= 1'b0;
         r_rd_addr_flag <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (r_state != IDLE && ss_n) begin
            // Deselect ends any frame; a partial one is simply discarded.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt <= '0;
                  if (!ss_n) r_state <= CHK_CMD;
               end
               CHK_CMD: begin
                  r_rx_shift <= {r_rx_shift[FW-2:0], mosi};
                  r_cnt      <= '0;
                  if (!mosi)
                     r_state <= WRITE;
                  else if (!r_rd_addr_flag)
                     r_state <= READ_ADD;
                  else
                     r_state <= READ_DATA;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (r_cnt == RX_LAST) begin
                     r_cnt <= '0;
                     if (w_cmd_ok) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        if (r_state == READ_ADD) r_rd_addr_flag <= 1'b1;
                        r_state <= (r_state == READ_DATA) ? WAIT_TX : DONE;
                     end else begin
                        r_state <= DONE;
                     end
                  end else begin
                     r_rx_shift <= {r_rx_shift[FW-2:0], mosi};
                     r_cnt      <= r_cnt + 1'b1;
                  end
               end
               WAIT_TX: begin
                  if (tx_valid) begin
                     r_miso     <= tx_data[ADDR_SIZE-1];
                     r_tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                     r_cnt      <= '0;
                     r_state    <= SHIFT_OUT;
                  end
               end
               SHIFT_OUT: begin
                  if (r_cnt == TX_LAST) begin
                     r_miso         <= 1'b0;
                     r_rd_addr_flag <= 1'b0;
                     r_cnt          <= '0;
                     r_state        <= DONE;
                  end else begin
                     r_miso     <= r_tx_shift[ADDR_SIZE-1];
                     r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
                     r_cnt      <= r_cnt + 1'b1;
                  end
               end
               DONE: begin
                  // Extra MOSI bits are ignored until ss_n rises.
                  r_state <= DONE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign miso     = r_miso;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI-to-RAM subsystem. It deserialises 10-bit MOSI frames into parallel command/data words for the downstream memory (`rx_data`/`rx_valid`). On a read-data frame it captures the memory's returned byte (`tx_data`/`tx_valid`) and shifts it out on MISO. It also tracks whether a read address has been loaded, so that read-address and read-data frames alternate.

## Interface
- `ADDR_SIZE`, default 8: memory word/address width; frame width is ADDR_SIZE+2.
- `clk` input 1: system clock; also the SPI bit clock, one bit per cycle.
- `rst_n` input 1: reset, synchronous, active-low.
- `ss_n` input 1: slave select, active-low; frame boundary.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first.
- `rx_data` output ADDR_SIZE+2: received frame; [ADDR_SIZE+1:ADDR_SIZE] = command, [ADDR_SIZE-1:0] = payload.
- `rx_valid` output 1: one-cycle strobe, `rx_data` valid.
- `tx_data` input ADDR_SIZE: read byte from memory.
- `tx_valid` input 1: `tx_data` valid strobe.

## Operation
- States:
  - `IDLE`: waiting for `ss_n`=0.
  - `CHK_CMD`: samples the first MOSI bit.
  - `WRITE`, `READ_ADD`, `READ_DATA`: shift the remaining frame bits.
  - `WAIT_TX`: waits for the memory's read byte.
  - `SHIFT_OUT`: drives the read byte on MISO.
  - `DONE`: frame complete, waiting for `ss_n` high.
- Transitions:
  - `IDLE` → `CHK_CMD` when `ss_n`=0.
  - In `CHK_CMD`, the sampled bit is frame bit ADDR_SIZE+1 and goes into the shift register. If 0 → `WRITE`; if 1 and `rd_addr_flag`=0 → `READ_ADD`; if 1 and `rd_addr_flag`=1 → `READ_DATA`.
  - `WRITE`/`READ_ADD`/`READ_DATA` shift the remaining ADDR_SIZE+1 bits under a bit counter. After the last bit: `rx_data` ← shift register, `rx_valid` pulses for one cycle.
  - After the pulse, `WRITE` and `READ_ADD` go to `DONE`, and `READ_ADD` also sets `rd_addr_flag`. `READ_DATA` goes to `WAIT_TX`.
  - `WAIT_TX`: on `tx_valid`=1, load `tx_data` into the output shift register → `SHIFT_OUT`. Wait indefinitely otherwise.
  - `SHIFT_OUT`: drive `miso` MSB first for ADDR_SIZE cycles, clear `rd_addr_flag` → `DONE`.
  - `DONE` → `IDLE` when `ss_n`=1.
- `ss_n`=1 in any non-`IDLE` state → `IDLE` next cycle. A partial frame produces no `rx_valid`; `rd_addr_flag` is unchanged; `miso` returns to 0.
- `ss_n` low for longer than a frame: extra MOSI bits are ignored in `DONE`. No second frame starts without an `ss_n` high.
- `tx_valid` outside `WAIT_TX` is ignored.
- Command bits are not checked by default; the memory decodes them.

## Timing
- Reset values: state `IDLE`, `miso` 0, `rx_valid` 0, `rx_data` 0, `rd_addr_flag` 0, counters 0. An `rst_n` low mid-frame aborts the frame exactly as reset.
- Cycle 0 is the first edge with `ss_n`=0 seen in `IDLE`.
  - Cycle 1: MSB sampled.
  - Cycles 2..ADDR_SIZE+2: remaining bits.
  - Cycle ADDR_SIZE+3: `rx_valid`=1 (cycle 11 for ADDR_SIZE=8).
- `rx_data` holds its value until the next `rx_valid`.
- Read byte (ADDR_SIZE=8):
  - Expected `tx_valid` at cycle 12 (one-cycle memory latency).
  - `miso` carries bit 7 in cycle 13 through bit 0 in cycle 20, registered.
  - `miso`=0 in all other cycles.
- Minimum `ss_n` high between frames: 1 cycle.

## Configuration
- `SPI_CMD_CHECK_EN` defined:
  - At frame end, command bits must match the state: `WRITE` expects 00 or 01, `READ_ADD` expects 10, `READ_DATA` expects 11.
  - On a mismatch: no `rx_valid`, `rd_addr_flag` unchanged, go to `DONE`.
- `SPI_CMD_CHECK_EN` undefined: every complete frame is forwarded as-is.

## Test plan
- Write address: `ss_n` low, MOSI 00_0000_0101 → `rx_valid` at cycle 11, `rx_data`=0x005; `rd_addr_flag` stays 0.
- Write data: MOSI 01_1010_0101 → `rx_data`=0x1A5 one-cycle pulse; `miso` stays 0.
- Read cycle: MOSI 10_0000_0101 → `rx_data`=0x205, flag=1. Next frame 11_xxxx_xxxx → `rx_data`=0x3xx; respond `tx_valid`+`tx_data`=0xA5 at cycle 12 → `miso` 1,0,1,0,0,1,0,1 on cycles 13–20; flag=0.
- Abort: `ss_n` high after 5 bits → no `rx_valid`, state `IDLE`, flag unchanged. The next full frame decodes correctly.
- Reset mid-`SHIFT_OUT`: `rst_n`=0 at cycle 16 → `miso`=0, flag=0, `IDLE` next cycle.
- With `SPI_CMD_CHECK_EN`: in `READ_ADD`, send 11_0000_0001 → no `rx_valid`, flag remains 0. Without the macro → `rx_valid`, `rx_data`=0x301, flag=1.
